fetch_stage_unit: RTL and testbench

Fetch stage of the 5-stage RISC-V pipeline: owns the PC, issues single-outstanding instruction reads to a variable-latency instruction memory, and writes the IF/ID pipeline register. It is the consumer of the hazard unit's StallF/StallD/FlushD/PCSrcE controls. It absorbs redirects that arrive mid-request by discarding stale responses, and inserts bubbles while memory is slow.

---
 rtl/fetch_stage_unit.sv | 132 +++++++++++++
 tb/tb_fetch_stage_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_unit.sv
// Fetch stage: owns PCF, keeps one instruction read in flight to a variable-latency
// memory, and fills the IF/ID register, discarding responses made stale by redirects.
module fetch_stage_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetchState_e;

  fetchState_e state;
  logic [31:0] pcF;
  logic [31:0] bufData;

  logic        grantTaken;
  logic        deliverNow;
  logic        captureNow;
  logic [31:0] deliverData;
  logic [31:0] pcPlus4F;

  assign IMemReq    = (state == REQ) && !StallF;
  assign IMemAddr   = pcF;
  assign grantTaken = IMemReq && IMemGnt;
  assign pcPlus4F   = pcF + 32'd4;

  // A response or buffered word reaches Decode only when no redirect and no stall.
  assign deliverNow  = !PCSrcE && !StallD &&
                       (((state == WAIT) && IMemRValid) || (state == HOLD));
  assign captureNow  = (state == WAIT) && IMemRValid && !PCSrcE && StallD;
  assign deliverData = (state == HOLD) ? bufData : IMemRData;
  assign FetchBusy   = !(((state == WAIT) && IMemRValid && !PCSrcE) || (state == HOLD));

  // NOTE: all clocked state uses non-blocking (<=) assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF <= RESET_PC;
      // A request still in flight at reset must have its response swallowed.
      if ((state == WAIT) || (state == DROP))
        state <= IMemRValid ? REQ : DROP;
      else if (grantTaken)
        state <= DROP;
      else
        state <= REQ;
    end else begin
      if (PCSrcE)
        pcF <= PCTargetE;
      else if (deliverNow)
        pcF <= pcPlus4F;

      unique case (state)
        REQ: begin
          if (grantTaken)
            state <= PCSrcE ? DROP : WAIT;
        end
        WAIT: begin
          if (IMemRValid) begin
            if (PCSrcE || !StallD)
              state <= REQ;
            else
              state <= HOLD;
          end else if (PCSrcE) begin
            state <= DROP;
          end
        end
        HOLD: begin
          if (PCSrcE || !StallD)
            state <= REQ;
        end
        DROP: begin
          if (IMemRValid)
            state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // NOTE: the skid buffer is pure datapath; its contents only matter in HOLD,
  // which is entered solely by writing it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (captureNow)
      bufData <= IMemRData;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
      ValidD   <= ValidD;
    end else if (deliverNow) begin
      InstrD   <= deliverData;
      PCD      <= pcF;
      PCPlus4D <= pcPlus4F;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage_unit.sv
// Bench for fetch_stage_unit: directed cycle table for the corner cases, then a random
// run against a memory model and a program-order scoreboard of delivered PCs.
module tb_fetch_stage_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        IMemReq, IMemGnt, IMemRValid;
  logic [31:0] IMemAddr, IMemRData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage_unit dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One record = inputs applied for one cycle plus outputs expected during that cycle.
  typedef struct {
    logic        rst, stallF, stallD, flushD, pcSrc;
    logic [31:0] target;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expInstr, expPcD, expPc4;
    logic        expBusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, sf, sd, fd, ps, input logic [31:0] tgt,
                              input logic g, rv, input logic [31:0] rd,
                              input logic eReq, input logic [31:0] eAddr, input logic eV,
                              input logic [31:0] eI, ePc, ePc4, input logic eB);
    vec_t v;
    v.rst = r; v.stallF = sf; v.stallD = sd; v.flushD = fd; v.pcSrc = ps; v.target = tgt;
    v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eV;
    v.expInstr = eI; v.expPcD = ePc; v.expPc4 = ePc4; v.expBusy = eB;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; StallF = v.stallF; StallD = v.stallD; FlushD = v.flushD;
    PCSrcE = v.pcSrc; PCTargetE = v.target;
    IMemGnt = v.gnt; IMemRValid = v.rvalid; IMemRData = v.rdata;
  endtask

  // Instruction memory contents as a fixed function of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Random-phase bookkeeping
  logic        memBusy, gntNow, rvNow;
  logic [31:0] memAddr, gntAddr;
  int          memWait;
  logic [31:0] expPc, prevTarget, prevInstr, prevPcD, prevPc4;
  logic        prevStallD, prevFlush, prevPcSrc, prevBusy, prevValid, newDelivery;
  int          deliveries;

  initial begin
    // r  sf sd fd ps target        g  rv rdata           req addr          v  instr          pcD           pc4   busy
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h0,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h0050_0093,  0,32'h0,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h4,        1,32'h0050_0093,32'h0,        32'h4, 1));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        0,1,32'hABCD_0001,  0,32'h4,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        0,0,32'h0,          0,32'h4,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        0,0,32'h0,          0,32'h4,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0,32'h0,          0,32'h4,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h8,        1,32'hABCD_0001,32'h4,        32'h8, 1));
    vecs.push_back(mk(0,0,0,0,1, 32'h100,      0,0,32'h0,          0,32'h8,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0,32'h0,          0,32'h100,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'hDEAD_BEEF,  0,32'h100,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h100,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,1, 32'h200,      0,1,32'h1111_1111,  0,32'h100,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,1, 32'h300,      0,0,32'h0,          1,32'h200,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,1,0,0,0, 32'h0,        0,0,32'h0,          0,32'h300,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,1, 32'hFFFF_FFFC,1,0,32'h0,          1,32'h300,      0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h2222_2222,  0,32'hFFFF_FFFC,0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'hFFFF_FFFC,0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h3333_3333,  0,32'hFFFF_FFFC,0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        1,0,32'h0,          1,32'h0,        1,32'h3333_3333,32'hFFFF_FFFC,32'h0, 1));
    vecs.push_back(mk(0,0,1,1,0, 32'h0,        0,0,32'h0,          0,32'h0,        1,32'h3333_3333,32'hFFFF_FFFC,32'h0, 1));
    vecs.push_back(mk(0,0,1,0,0, 32'h0,        0,0,32'h0,          0,32'h0,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h4444_4444,  0,32'h0,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0,32'h0,          1,32'h4,        1,32'h4444_4444,32'h0,        32'h4, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h4,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(1,0,0,0,0, 32'h0,        0,0,32'h0,          0,32'h4,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0,32'h0,          0,32'h0,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h5555_5555,  0,32'h0,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        1,0,32'h0,          1,32'h0,        0,NOP,          32'h0,        32'h0, 1));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,1,32'h6666_6666,  0,32'h0,        0,NOP,          32'h0,        32'h0, 0));
    vecs.push_back(mk(0,0,0,0,0, 32'h0,        0,0,32'h0,          1,32'h4,        1,32'h6666_6666,32'h0,        32'h4, 1));

    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;
    repeat (2) @(posedge clk);

    // Directed cycle table
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d IMemReq", i),   IMemReq,   vecs[i].expReq);
      check($sformatf("v%0d IMemAddr", i),  IMemAddr,  vecs[i].expAddr);
      check($sformatf("v%0d ValidD", i),    ValidD,    vecs[i].expValid);
      check($sformatf("v%0d InstrD", i),    InstrD,    vecs[i].expInstr);
      check($sformatf("v%0d PCD", i),       PCD,       vecs[i].expPcD);
      check($sformatf("v%0d PCPlus4D", i),  PCPlus4D,  vecs[i].expPc4);
      check($sformatf("v%0d FetchBusy", i), FetchBusy, vecs[i].expBusy);
    end

    // Random phase: reset, then a randomly slow memory and random hazard controls
    @(posedge clk); #1;
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    IMemGnt = 1'b0; IMemRValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    memBusy = 1'b0; memWait = 0; memAddr = 32'h0; gntNow = 1'b0; rvNow = 1'b0; gntAddr = 32'h0;
    expPc = 32'h0; prevFlush = 1'b1; prevStallD = 1'b0; prevPcSrc = 1'b0; prevBusy = 1'b1;
    prevTarget = 32'h0; prevInstr = NOP; prevPcD = 32'h0; prevPc4 = 32'h0; prevValid = 1'b0;
    deliveries = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      StallF    = ($urandom_range(0, 7) == 0);
      StallD    = ($urandom_range(0, 3) == 0);
      PCSrcE    = ($urandom_range(0, 11) == 0);
      FlushD    = PCSrcE && ($urandom_range(0, 1) == 1);
      PCTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_0FFC);
      rvNow      = memBusy && (memWait == 0);
      IMemRValid = rvNow;
      IMemRData  = rvNow ? memWord(memAddr) : $urandom();
      IMemGnt    = 1'b0;
      @(negedge clk);

      // IF/ID contents follow from last cycle's Decode controls
      newDelivery = 1'b0;
      if (prevFlush) begin
        check("rand bubble after flush ValidD", ValidD, 1'b0);
        check("rand bubble after flush InstrD", InstrD, NOP);
      end else if (prevStallD) begin
        check("rand stall hold InstrD", InstrD, prevInstr);
        check("rand stall hold PCD", {PCD[31:1], ValidD}, {prevPcD[31:1], prevValid});
      end else if (ValidD) begin
        newDelivery = 1'b1;
        deliveries++;
        check("rand program order PCD", PCD, expPc);
        check("rand InstrD matches memory", InstrD, memWord(PCD));
        check("rand PCPlus4D", PCPlus4D, expPc + 32'd4);
      end else begin
        check("rand bubble InstrD", InstrD, NOP);
        check("rand bubble PCD/PCPlus4D", PCD | PCPlus4D, 32'h0);
      end
      if (!prevFlush && !prevStallD && !prevPcSrc)
        check("rand FetchBusy vs delivery", newDelivery, !prevBusy);

      if (prevPcSrc)
        expPc = prevTarget;
      else if (newDelivery)
        expPc = expPc + 32'd4;

      check("rand request while StallF", IMemReq & StallF, 1'b0);
      check("rand second outstanding request", IMemReq & memBusy, 1'b0);
      if (IMemReq) begin
        check("rand IMemAddr", IMemAddr, expPc);
        if ($urandom_range(0, 2) != 0) IMemGnt = 1'b1;
      end

      gntNow = IMemGnt; gntAddr = IMemAddr;
      prevStallD = StallD; prevFlush = FlushD; prevPcSrc = PCSrcE; prevTarget = PCTargetE;
      prevBusy = FetchBusy; prevInstr = InstrD; prevPcD = PCD; prevPc4 = PCPlus4D; prevValid = ValidD;

      @(posedge clk); #1;
      if (rvNow) memBusy = 1'b0;
      else if (memBusy) memWait--;
      if (gntNow) begin
        memBusy = 1'b1;
        memAddr = gntAddr;
        memWait = $urandom_range(0, 3);
      end
    end
    check("rand forward progress", deliveries > 200, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
